morse_round_sequencer: RTL and testbench

Game-round controller for the Morse number game. It steps the 4-bit ROM address `q` that feeds the number decoder and captures the decoded target. It shows the target for a fixed window, then waits for the player's guess with a timeout. It keeps score and lives, and ends the game on win or loss. It sits between the ROM/decoder datapath and the display/input front end.

---
 rtl/morse_round_sequencer_pkg.sv | 27 ++
 rtl/morse_round_sequencer_if.sv | 29 ++
 rtl/morse_round_timer.sv | 32 +++
 rtl/morse_round_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_morse_round_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/morse_round_sequencer_pkg.sv
// Shared constants and state encoding for the Morse number game round sequencer.
package morse_round_sequencer_pkg;

  localparam int unsigned NUM_WIDTH      = 4;
  localparam int unsigned LIVES_WIDTH    = 2;
  localparam int unsigned ROUNDS_DEFAULT = 15;
  localparam int unsigned LIVES_DEFAULT  = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_SHOW  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_CHECK = 3'd5,
    ST_NEXT  = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  // Timer width: clog2 of the longer window, never below one bit.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/morse_round_sequencer_if.sv
// Player/display side of the round sequencer.
//   master: front end (drives start/guess, observes round status)
//   slave : sequencer
interface morse_round_sequencer_if;
  import morse_round_sequencer_pkg::*;

  logic                   start;
  logic [NUM_WIDTH-1:0]   guess;
  logic                   guess_valid;
  logic [NUM_WIDTH-1:0]   target;
  logic                   show;
  logic                   await_guess;
  logic                   correct;
  logic                   wrong;
  logic [NUM_WIDTH-1:0]   score;
  logic [LIVES_WIDTH-1:0] lives;
  logic                   game_over;
  logic                   win;

  modport master (
    output start, guess, guess_valid,
    input  target, show, await_guess, correct, wrong, score, lives, game_over, win
  );

  modport slave (
    input  start, guess, guess_valid,
    output target, show, await_guess, correct, wrong, score, lives, game_over, win
  );
endinterface

// File: rtl/morse_round_timer.sv
// Up-counter with synchronous clear and a terminal-count compare; shared by
// the SHOW and WAIT windows.
//   clear    : reset count to 0 (wins over inc)
//   inc      : advance count by one
//   terminal : value at which done_c asserts
//   done_c   : combinational count == terminal
module morse_round_timer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] terminal,
  output logic             done_c
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign done_c = (count_q == terminal);

endmodule

// File: rtl/morse_round_sequencer.sv
// Game-round controller: steps the ROM address q, latches the decoded target,
// shows it for SHOW_CYCLES, waits up to TIMEOUT_CYCLES for a guess, then
// scores it. Ends on win (all rounds played) or loss (lives exhausted).
//   clk, rst_n   : clock, async active-low reset
//   morse_number : external decoder output for q
//   q            : ROM/decoder address
//   bus          : start/guess in, target/show/await_guess/pulses/score/lives/flags out
module morse_round_sequencer
  import morse_round_sequencer_pkg::*;
#(
  parameter int unsigned ROUNDS         = ROUNDS_DEFAULT,
  parameter int unsigned SHOW_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned LIVES          = LIVES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_WIDTH-1:0] morse_number,
  output logic [NUM_WIDTH-1:0] q,
  morse_round_sequencer_if.slave bus
);

  localparam int unsigned TMR_WIDTH = timer_width(SHOW_CYCLES, TIMEOUT_CYCLES);
  localparam logic [TMR_WIDTH-1:0]   SHOW_TC   = TMR_WIDTH'(SHOW_CYCLES - 1);
  localparam logic [TMR_WIDTH-1:0]   WAIT_TC   = TMR_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_WIDTH-1:0]   LAST_Q    = NUM_WIDTH'(ROUNDS - 1);
  localparam logic [NUM_WIDTH-1:0]   SCORE_MAX = {NUM_WIDTH{1'b1}};
  localparam logic [LIVES_WIDTH-1:0] LIVES_INIT = LIVES_WIDTH'(LIVES);

  state_e                 state_q, state_d;
  logic [NUM_WIDTH-1:0]   q_q, q_d;
  logic [NUM_WIDTH-1:0]   target_q, target_d;
  logic [NUM_WIDTH-1:0]   score_q, score_d;
  logic [LIVES_WIDTH-1:0] lives_q, lives_d;
  logic [NUM_WIDTH-1:0]   guess_q, guess_d;
  logic                   timeout_q, timeout_d;
  logic                   show_q, show_d;
  logic                   await_q, await_d;
  logic                   correct_q, correct_d;
  logic                   wrong_q, wrong_d;
  logic                   game_over_q, game_over_d;
  logic                   win_q, win_d;

  logic                   tmr_clear, tmr_inc, tmr_done_c;
  logic [TMR_WIDTH-1:0]   tmr_terminal;

  morse_round_timer #(.WIDTH(TMR_WIDTH)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (tmr_clear),
    .inc      (tmr_inc),
    .terminal (tmr_terminal),
    .done_c   (tmr_done_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      q_q         <= '0;
      target_q    <= '0;
      score_q     <= '0;
      lives_q     <= LIVES_INIT;
      guess_q     <= '0;
      timeout_q   <= 1'b0;
      show_q      <= 1'b0;
      await_q     <= 1'b0;
      correct_q   <= 1'b0;
      wrong_q     <= 1'b0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      target_q    <= target_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      guess_q     <= guess_d;
      timeout_q   <= timeout_d;
      show_q      <= show_d;
      await_q     <= await_d;
      correct_q   <= correct_d;
      wrong_q     <= wrong_d;
      game_over_q <= game_over_d;
      win_q       <= win_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    q_d          = q_q;
    target_d     = target_q;
    score_d      = score_q;
    lives_d      = lives_q;
    guess_d      = guess_q;
    timeout_d    = timeout_q;
    correct_d    = 1'b0;
    wrong_d      = 1'b0;
    game_over_d  = game_over_q;
    win_d        = win_q;
    tmr_clear    = 1'b0;
    tmr_inc      = 1'b0;
    tmr_terminal = '0;
    show_d       = 1'b0;
    await_d      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d     = ST_FETCH;
          q_d         = '0;
          score_d     = '0;
          lives_d     = LIVES_INIT;
          game_over_d = 1'b0;
          win_d       = 1'b0;
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        target_d  = morse_number;
        tmr_clear = 1'b1;
        state_d   = ST_SHOW;
      end
      ST_SHOW: begin
        tmr_terminal = SHOW_TC;
        if (tmr_done_c) begin
          tmr_clear = 1'b1;
          state_d   = ST_WAIT;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_WAIT: begin
        // A guess on the terminal cycle takes priority over the timeout.
        tmr_terminal = WAIT_TC;
        if (bus.guess_valid) begin
          guess_d   = bus.guess;
          timeout_d = 1'b0;
          tmr_clear = 1'b1;
          state_d   = ST_CHECK;
        end else if (tmr_done_c) begin
          timeout_d = 1'b1;
          tmr_clear = 1'b1;
          state_d   = ST_CHECK;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_CHECK: begin
        if (!timeout_q && (guess_q == target_q)) begin
          correct_d = 1'b1;
          if (score_q != SCORE_MAX) score_d = score_q + NUM_WIDTH'(1);
          state_d = ST_NEXT;
        end else begin
          wrong_d = 1'b1;
          lives_d = lives_q - LIVES_WIDTH'(1);
          if (lives_q == LIVES_WIDTH'(1)) begin
            game_over_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        if (q_q == LAST_Q) begin
          win_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          q_d     = q_q + NUM_WIDTH'(1);
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    show_d  = (state_d == ST_SHOW);
    await_d = (state_d == ST_WAIT);
  end

  assign q               = q_q;
  assign bus.target      = target_q;
  assign bus.show        = show_q;
  assign bus.await_guess = await_q;
  assign bus.correct     = correct_q;
  assign bus.wrong       = wrong_q;
  assign bus.score       = score_q;
  assign bus.lives       = lives_q;
  assign bus.game_over   = game_over_q;
  assign bus.win         = win_q;

endmodule

// File: tb/tb_morse_round_sequencer.sv
// Self-checking bench for morse_round_sequencer: a 3-round instance (A) and a
// 15-round instance (B), each fed by a decoder model mapping 15 to 0.
module tb_morse_round_sequencer;
  import morse_round_sequencer_pkg::*;

  localparam int unsigned SHOW_A = 4;
  localparam int unsigned TO_A   = 8;
  localparam int unsigned ROUNDS_A = 3;

  typedef struct packed {
    logic       is_correct;
    logic [3:0] score;
    logic [1:0] lives;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] qa, qb, mna, mnb;
  int         n_cmp = 0;
  int         n_err = 0;
  int         q15_count = 0;
  exp_t       exp_q[$];
  logic [3:0] m_score;
  logic [1:0] m_lives;
  logic [3:0] m_q;

  morse_round_sequencer_if ifa();
  morse_round_sequencer_if ifb();

  function automatic logic [3:0] dec(input logic [3:0] a);
    return (a == 4'd15) ? 4'd0 : a;
  endfunction

  assign mna = dec(qa);
  assign mnb = dec(qb);

  always #5 clk = ~clk;

  always @(negedge clk) if (qb === 4'd15) q15_count++;

  morse_round_sequencer #(.ROUNDS(3), .SHOW_CYCLES(SHOW_A), .TIMEOUT_CYCLES(TO_A), .LIVES(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .morse_number(mna), .q(qa), .bus(ifa));

  morse_round_sequencer #(.ROUNDS(15), .SHOW_CYCLES(2), .TIMEOUT_CYCLES(4), .LIVES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .morse_number(mnb), .q(qb), .bus(ifb));

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic start_a;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    m_q = 4'd0; m_score = 4'd0; m_lives = 2'd3;
  endtask

  // Plays one round on instance A; reports lengths and the pulse seen.
  task automatic drive_round_a(input bit guess_en, input int guess_at, input logic [3:0] g,
                               input bit show_poke, input logic [3:0] poke_val,
                               output int pre_len, output int show_len, output int pulse_lat,
                               output logic got_c, output logic got_w,
                               output bit spurious, output bit hung);
    pre_len = 0; show_len = 0; pulse_lat = -1; got_c = 0; got_w = 0; spurious = 0; hung = 0;
    while (ifa.show !== 1'b1) begin
      if (pre_len >= 40) begin hung = 1; return; end
      tick(); pre_len++;
    end
    while (ifa.show === 1'b1) begin
      if (ifa.correct === 1'b1 || ifa.wrong === 1'b1) spurious = 1;
      if (show_poke && show_len == 0) begin ifa.guess = poke_val; ifa.guess_valid = 1'b1; end
      if (show_len >= 40) begin hung = 1; return; end
      tick(); ifa.guess_valid = 1'b0; show_len++;
    end
    for (int n = 0; n <= 60; n++) begin
      if (ifa.correct === 1'b1 || ifa.wrong === 1'b1) begin
        got_c = ifa.correct; got_w = ifa.wrong; pulse_lat = n; return;
      end
      if (guess_en && n == guess_at) begin ifa.guess = g; ifa.guess_valid = 1'b1; end
      tick(); ifa.guess_valid = 1'b0;
    end
    hung = 1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ifa.start = 1'($urandom_range(0, 1)); ifb.start = 1'($urandom_range(0, 1));
    ifa.guess = 4'd0; ifa.guess_valid = 1'b0; ifb.guess = 4'd0; ifb.guess_valid = 1'b0;
    repeat (3) tick();
    n_cmp++; if (qa !== 4'd0) begin n_err++; $display("FAIL reset_q: got %0d want 0", qa); end
    n_cmp++; if (ifa.target !== 4'd0) begin n_err++; $display("FAIL reset_target: got %0d want 0", ifa.target); end
    n_cmp++; if (ifa.score !== 4'd0) begin n_err++; $display("FAIL reset_score: got %0d want 0", ifa.score); end
    n_cmp++; if (ifa.lives !== 2'd3) begin n_err++; $display("FAIL reset_lives: got %0d want 3", ifa.lives); end
    n_cmp++; if ({ifa.show, ifa.await_guess, ifa.correct, ifa.wrong, ifa.game_over, ifa.win} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want 000000",
        {ifa.show, ifa.await_guess, ifa.correct, ifa.wrong, ifa.game_over, ifa.win}); end
    n_cmp++; if (qb !== 4'd0 || ifb.lives !== 2'd3) begin
      n_err++; $display("FAIL reset_b: got q=%0d lives=%0d want q=0 lives=3", qb, ifb.lives); end
    ifa.start = 1'b0; ifb.start = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    n_cmp++; if (ifa.show !== 1'b0 || ifa.await_guess !== 1'b0 || ifb.show !== 1'b0) begin
      n_err++; $display("FAIL idle_hold: got show=%b await=%b show_b=%b want 0 0 0",
        ifa.show, ifa.await_guess, ifb.show); end
  endtask

  task automatic test_perfect_game;
    exp_t e; int pre, sl, lat; logic gc, gw; bit sp, hg;
    start_a();
    for (int r = 0; r < int'(ROUNDS_A); r++) begin
      m_score = m_score + 4'd1;
      exp_q.push_back('{is_correct: 1'b1, score: m_score, lives: m_lives});
      drive_round_a(1'b1, 0, dec(m_q), 1'b0, 4'd0, pre, sl, lat, gc, gw, sp, hg);
      e = exp_q.pop_front();
      if (hg) begin n_cmp++; n_err++; $display("FAIL perfect_hang r%0d: got none want pulse", r); return; end
      n_cmp++; if (gc !== e.is_correct || gw !== !e.is_correct) begin
        n_err++; $display("FAIL perfect_pulse r%0d: got c=%b w=%b want c=%b", r, gc, gw, e.is_correct); end
      n_cmp++; if (pre != ((r == 0) ? 2 : 3)) begin
        n_err++; $display("FAIL perfect_show_delay r%0d: got %0d want %0d", r, pre, (r == 0) ? 2 : 3); end
      n_cmp++; if (sl != int'(SHOW_A) || sp) begin
        n_err++; $display("FAIL perfect_show_len r%0d: got %0d spurious=%b want %0d", r, sl, sp, SHOW_A); end
      n_cmp++; if (lat != 2) begin n_err++; $display("FAIL perfect_latency r%0d: got %0d want 2", r, lat); end
      n_cmp++; if (ifa.score !== e.score || ifa.lives !== e.lives) begin
        n_err++; $display("FAIL perfect_score r%0d: got %0d/%0d want %0d/%0d", r, ifa.score, ifa.lives, e.score, e.lives); end
      n_cmp++; if (ifa.target !== dec(m_q)) begin
        n_err++; $display("FAIL perfect_target r%0d: got %0d want %0d", r, ifa.target, dec(m_q)); end
      if (m_q != 4'(ROUNDS_A - 1)) m_q = m_q + 4'd1;
    end
    tick();
    n_cmp++; if (ifa.win !== 1'b1 || ifa.game_over !== 1'b0 || qa !== 4'd2 || ifa.score !== 4'd3) begin
      n_err++; $display("FAIL perfect_end: got win=%b go=%b q=%0d score=%0d want 1 0 2 3",
        ifa.win, ifa.game_over, qa, ifa.score); end
  endtask

  task automatic test_timeouts;
    exp_t e; int pre, sl, lat; logic gc, gw; bit sp, hg;
    start_a();
    n_cmp++; if (ifa.win !== 1'b0 || ifa.score !== 4'd0 || ifa.lives !== 2'd3 || qa !== 4'd0) begin
      n_err++; $display("FAIL restart_after_win: got win=%b score=%0d lives=%0d q=%0d want 0 0 3 0",
        ifa.win, ifa.score, ifa.lives, qa); end
    for (int r = 0; r < 3; r++) begin
      m_lives = m_lives - 2'd1;
      exp_q.push_back('{is_correct: 1'b0, score: m_score, lives: m_lives});
      drive_round_a(1'b0, 0, 4'd0, 1'b0, 4'd0, pre, sl, lat, gc, gw, sp, hg);
      e = exp_q.pop_front();
      if (hg) begin n_cmp++; n_err++; $display("FAIL timeout_hang r%0d: got none want pulse", r); return; end
      n_cmp++; if (gc !== e.is_correct || gw !== !e.is_correct) begin
        n_err++; $display("FAIL timeout_pulse r%0d: got c=%b w=%b want c=%b", r, gc, gw, e.is_correct); end
      n_cmp++; if (lat != int'(TO_A) + 1) begin
        n_err++; $display("FAIL timeout_latency r%0d: got %0d want %0d", r, lat, TO_A + 1); end
      n_cmp++; if (ifa.score !== e.score || ifa.lives !== e.lives) begin
        n_err++; $display("FAIL timeout_score r%0d: got %0d/%0d want %0d/%0d", r, ifa.score, ifa.lives, e.score, e.lives); end
      if (m_lives != 2'd0 && m_q != 4'(ROUNDS_A - 1)) m_q = m_q + 4'd1;
    end
    tick();
    n_cmp++; if (ifa.game_over !== 1'b1 || ifa.win !== 1'b0 || qa !== 4'd2 || ifa.lives !== 2'd0) begin
      n_err++; $display("FAIL timeout_end: got go=%b win=%b q=%0d lives=%0d want 1 0 2 0",
        ifa.game_over, ifa.win, qa, ifa.lives); end
  endtask

  task automatic test_show_guess_collision;
    exp_t e; int pre, sl, lat; logic gc, gw; bit sp, hg;
    bit         poke[3]  = '{1'b1, 1'b0, 1'b1};
    int         at[3]    = '{7, 3, 1};
    logic [3:0] gv[3]    = '{4'd0, 4'd5, 4'd9};
    start_a();
    n_cmp++; if (ifa.game_over !== 1'b0 || ifa.lives !== 2'd3 || ifa.score !== 4'd0 || qa !== 4'd0) begin
      n_err++; $display("FAIL restart_after_loss: got go=%b lives=%0d score=%0d q=%0d want 0 3 0 0",
        ifa.game_over, ifa.lives, ifa.score, qa); end
    for (int r = 0; r < 3; r++) begin
      if (gv[r] == dec(m_q)) m_score = m_score + 4'd1; else m_lives = m_lives - 2'd1;
      exp_q.push_back('{is_correct: (gv[r] == dec(m_q)), score: m_score, lives: m_lives});
      drive_round_a(1'b1, at[r], gv[r], poke[r], dec(m_q), pre, sl, lat, gc, gw, sp, hg);
      e = exp_q.pop_front();
      if (hg) begin n_cmp++; n_err++; $display("FAIL collide_hang r%0d: got none want pulse", r); return; end
      n_cmp++; if (gc !== e.is_correct || gw !== !e.is_correct) begin
        n_err++; $display("FAIL collide_pulse r%0d: got c=%b w=%b want c=%b", r, gc, gw, e.is_correct); end
      n_cmp++; if (sl != int'(SHOW_A) || sp) begin
        n_err++; $display("FAIL collide_show r%0d: got len=%0d spurious=%b want %0d", r, sl, sp, SHOW_A); end
      n_cmp++; if (lat != at[r] + 2) begin
        n_err++; $display("FAIL collide_latency r%0d: got %0d want %0d", r, lat, at[r] + 2); end
      n_cmp++; if (ifa.score !== e.score || ifa.lives !== e.lives) begin
        n_err++; $display("FAIL collide_score r%0d: got %0d/%0d want %0d/%0d", r, ifa.score, ifa.lives, e.score, e.lives); end
      if (m_lives != 2'd0 && m_q != 4'(ROUNDS_A - 1)) m_q = m_q + 4'd1;
    end
    tick();
    n_cmp++; if (ifa.win !== 1'b1 || ifa.lives !== 2'd1 || ifa.score !== 4'd1) begin
      n_err++; $display("FAIL collide_end: got win=%b lives=%0d score=%0d want 1 1 1", ifa.win, ifa.lives, ifa.score); end
  endtask

  task automatic test_reset_mid_wait;
    int pre, sl, lat, n; logic gc, gw; bit sp, hg;
    start_a();
    drive_round_a(1'b1, 0, dec(4'd0), 1'b0, 4'd0, pre, sl, lat, gc, gw, sp, hg);
    n = 0;
    while (ifa.await_guess !== 1'b1 && n < 40) begin tick(); n++; end
    n_cmp++; if (n >= 40 || qa !== 4'd1 || ifa.score !== 4'd1) begin
      n_err++; $display("FAIL midwait_setup: got n=%0d q=%0d score=%0d want <40 1 1", n, qa, ifa.score); end
    tick(); tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (qa !== 4'd0 || ifa.score !== 4'd0 || ifa.lives !== 2'd3 || ifa.target !== 4'd0) begin
      n_err++; $display("FAIL midwait_reset_vals: got q=%0d score=%0d lives=%0d target=%0d want 0 0 3 0",
        qa, ifa.score, ifa.lives, ifa.target); end
    n_cmp++; if ({ifa.await_guess, ifa.show, ifa.correct, ifa.wrong} !== 4'b0) begin
      n_err++; $display("FAIL midwait_reset_flags: got %b want 0000",
        {ifa.await_guess, ifa.show, ifa.correct, ifa.wrong}); end
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    n_cmp++; if (ifa.correct !== 1'b0 || ifa.wrong !== 1'b0 || ifa.await_guess !== 1'b0) begin
      n_err++; $display("FAIL midwait_after: got c=%b w=%b await=%b want 0 0 0", ifa.correct, ifa.wrong, ifa.await_guess); end
  endtask

  task automatic test_decoder_boundary;
    exp_t e; int n; int q15_start; logic [3:0] sc;
    q15_start = q15_count;
    sc = 4'd0;
    ifb.start = 1'b1; tick(); ifb.start = 1'b0;
    for (int r = 0; r < 15; r++) begin
      n = 0;
      while (ifb.await_guess !== 1'b1 && n < 30) begin tick(); n++; end
      if (n >= 30) begin n_cmp++; n_err++; $display("FAIL boundary_hang r%0d: got none want await", r); return; end
      n_cmp++; if (qb !== 4'(r) || ifb.target !== 4'(r)) begin
        n_err++; $display("FAIL boundary_target r%0d: got q=%0d target=%0d want %0d", r, qb, ifb.target, r); end
      sc = (sc == 4'd15) ? 4'd15 : sc + 4'd1;
      exp_q.push_back('{is_correct: 1'b1, score: sc, lives: 2'd3});
      ifb.guess = 4'(r); ifb.guess_valid = 1'b1;
      tick(); ifb.guess_valid = 1'b0;
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (ifb.correct !== e.is_correct || ifb.score !== e.score || ifb.lives !== e.lives) begin
        n_err++; $display("FAIL boundary_score r%0d: got c=%b score=%0d lives=%0d want %b %0d %0d",
          r, ifb.correct, ifb.score, ifb.lives, e.is_correct, e.score, e.lives); end
    end
    tick();
    n_cmp++; if (ifb.win !== 1'b1 || qb !== 4'd14 || ifb.score !== 4'd15 || ifb.game_over !== 1'b0) begin
      n_err++; $display("FAIL boundary_end: got win=%b q=%0d score=%0d go=%b want 1 14 15 0",
        ifb.win, qb, ifb.score, ifb.game_over); end
    n_cmp++; if (q15_count != q15_start) begin
      n_err++; $display("FAIL boundary_q15: got %0d cycles at q=15 want 0", q15_count - q15_start); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_perfect_game();
    test_timeouts();
    test_show_guess_collision();
    test_reset_mid_wait();
    test_decoder_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
